// File: rtl/mem_arb_pkg.sv
// -----------------------------------------------------------------------------
// mem_arb_pkg
// Shared types and helpers for the multi-core memory request arbiter.
//   arb_state_t : arbiter FSM states (IDLE, WAIT, RESP)
//   core_id_w() : width of a core index, at least 1 bit
//   cnt_w()     : width of the watchdog counter, at least 1 bit
//   ERR_RDATA   : load data returned on a watchdog abort (all ones); sliced
//                 to the data width by the user
// -----------------------------------------------------------------------------
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } arb_state_t;

  // Widest data bus the all-ones constant covers.
  localparam int MAX_DATA_WIDTH = 1024;
  localparam logic [MAX_DATA_WIDTH-1:0] ERR_RDATA = '1;

  function automatic int core_id_w(input int num_cores);
    return (num_cores > 1) ? $clog2(num_cores) : 1;
  endfunction

  // Counter must hold values up to TIMEOUT_CYCLES-1.
  function automatic int cnt_w(input int timeout_cycles);
    return (timeout_cycles > 0) ? $clog2(timeout_cycles + 1) : 1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// -----------------------------------------------------------------------------
// rr_pick
// Combinational rotate-priority encoder. Returns the first asserted request
// found when scanning upward from rr_ptr, wrapping modulo NUM_CORES.
// Ports:
//   req     in  [NUM_CORES]  request vector
//   rr_ptr  in  [CORE_ID_W]  highest-priority index (must be < NUM_CORES)
//   grant   out [CORE_ID_W]  selected index (0 when no request)
//   any_req out 1            at least one request present
// -----------------------------------------------------------------------------
module rr_pick
  import mem_arb_pkg::*;
#(
  parameter int NUM_CORES = 1,
  parameter int CORE_ID_W = core_id_w(NUM_CORES)
) (
  input  logic [NUM_CORES-1:0] req,
  input  logic [CORE_ID_W-1:0] rr_ptr,
  output logic [CORE_ID_W-1:0] grant,
  output logic                 any_req
);

  int                   idx_full;
  logic [CORE_ID_W-1:0] idx;

  // NOTE: every variable written here gets a default first, so no path
  // leaves a value unassigned and no latch is inferred.
  always_comb begin
    grant    = '0;
    any_req  = 1'b0;
    idx_full = 0;
    idx      = '0;
    for (int i = 0; i < NUM_CORES; i++) begin
      idx_full = (int'(rr_ptr) + i) % NUM_CORES;
      idx      = CORE_ID_W'(idx_full);
      if (!any_req && req[idx]) begin
        grant   = idx;
        any_req = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mem_req_arbiter.sv
// -----------------------------------------------------------------------------
// mem_req_arbiter
// Round-robin arbiter between NUM_CORES cores and one memory controller port.
// One transaction in flight at a time: IDLE picks a core and latches its
// request, WAIT holds it until m_ready or the watchdog fires, RESP pulses the
// core's ready for one cycle and advances the round-robin pointer.
// Ports:
//   clk, rst_n                    clock, async active-low reset
//   core_req/write/addr/wdata     per-core request, held until core_ready
//   core_rdata                    per-core load data, held between responses
//   core_ready, core_err          one-cycle completion pulse / abort flag
//   m_req/write/addr/wdata        registered request toward the controller
//   m_rdata, m_ready              controller response (sampled only in WAIT)
//   grant_id                      current or last granted core
//   busy                          high in WAIT and RESP
// -----------------------------------------------------------------------------
module mem_req_arbiter
  import mem_arb_pkg::*;
#(
  parameter  int NUM_CORES      = 1,
  parameter  int ADDR_WIDTH     = 64,
  parameter  int DATA_WIDTH     = 64,
  parameter  int TIMEOUT_CYCLES = 256,
  localparam int CORE_ID_W      = core_id_w(NUM_CORES)
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic [NUM_CORES-1:0]                 core_req,
  input  logic [NUM_CORES-1:0]                 core_write,
  input  logic [NUM_CORES-1:0][ADDR_WIDTH-1:0] core_addr,
  input  logic [NUM_CORES-1:0][DATA_WIDTH-1:0] core_wdata,
  output logic [NUM_CORES-1:0][DATA_WIDTH-1:0] core_rdata,
  output logic [NUM_CORES-1:0]                 core_ready,
  output logic [NUM_CORES-1:0]                 core_err,
  output logic                                 m_req,
  output logic                                 m_write,
  output logic [ADDR_WIDTH-1:0]                m_addr,
  output logic [DATA_WIDTH-1:0]                m_wdata,
  input  logic [DATA_WIDTH-1:0]                m_rdata,
  input  logic                                 m_ready,
  output logic [CORE_ID_W-1:0]                 grant_id,
  output logic                                 busy
);

  localparam int                   CNT_W     = cnt_w(TIMEOUT_CYCLES);
  localparam bit                   WDOG_EN   = (TIMEOUT_CYCLES != 0);
  localparam logic [CNT_W-1:0]     CNT_LAST  = WDOG_EN ? CNT_W'(TIMEOUT_CYCLES - 1) : '0;
  localparam logic [CORE_ID_W-1:0] LAST_CORE = CORE_ID_W'(NUM_CORES - 1);

  arb_state_t           state;
  arb_state_t           state_nxt;
  logic [CORE_ID_W-1:0] rr_ptr;
  logic [CORE_ID_W-1:0] pick_id;
  logic                 any_req;
  logic [CNT_W-1:0]     wd_cnt;
  logic                 timeout_hit;

  rr_pick #(
    .NUM_CORES (NUM_CORES),
    .CORE_ID_W (CORE_ID_W)
  ) u_rr_pick (
    .req     (core_req),
    .rr_ptr  (rr_ptr),
    .grant   (pick_id),
    .any_req (any_req)
  );

  // m_ready takes priority over this in WAIT; see the datapath below.
  assign timeout_hit = WDOG_EN && (wd_cnt == CNT_LAST);

  // ---------------------------------------------------------------------------
  // FSM: state register and next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (any_req) state_nxt = WAIT;
      WAIT:    if (m_ready || timeout_hit) state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath: request latch, watchdog, response registers, round-robin pointer
  // ---------------------------------------------------------------------------
  // NOTE: core_rdata is a register array but it sits on the output ports, and
  // every output must read zero while reset is asserted, so it is reset too.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr     <= '0;
      wd_cnt     <= '0;
      grant_id   <= '0;
      busy       <= 1'b0;
      m_req      <= 1'b0;
      m_write    <= 1'b0;
      m_addr     <= '0;
      m_wdata    <= '0;
      core_rdata <= '0;
      core_ready <= '0;
      core_err   <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (any_req) begin
            grant_id <= pick_id;
            m_req    <= 1'b1;
            m_write  <= core_write[pick_id];
            m_addr   <= core_addr[pick_id];
            m_wdata  <= core_wdata[pick_id];
            busy     <= 1'b1;
            wd_cnt   <= '0;
          end
        end
        WAIT: begin
          if (m_ready) begin
            if (!m_write) core_rdata[grant_id] <= m_rdata;
            core_ready[grant_id] <= 1'b1;
            core_err[grant_id]   <= 1'b0;
            m_req                <= 1'b0;
          end else if (timeout_hit) begin
            if (!m_write) core_rdata[grant_id] <= ERR_RDATA[DATA_WIDTH-1:0];
            core_ready[grant_id] <= 1'b1;
            core_err[grant_id]   <= 1'b1;
            m_req                <= 1'b0;
          end else if (wd_cnt != CNT_LAST) begin
            // Saturates; with the watchdog disabled CNT_LAST is 0 and it never moves.
            wd_cnt <= wd_cnt + 1'b1;
          end
        end
        RESP: begin
          core_ready <= '0;
          core_err   <= '0;
          busy       <= 1'b0;
          rr_ptr     <= (grant_id == LAST_CORE) ? '0 : grant_id + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_req_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_req_arbiter
// Scoreboard bench: directed stimulus pushes the expected grant and response
// for each request; a monitor pops and compares whenever m_req rises or a
// core_ready pulse appears. A controller model answers after a programmable
// number of WAIT cycles (or never).
// -----------------------------------------------------------------------------
module tb_mem_req_arbiter;

  localparam int NC  = 4;
  localparam int AW  = 64;
  localparam int DW  = 64;
  localparam int TO  = 4;
  localparam int IDW = 2;

  localparam logic [63:0] XK   = 64'h5A5A_0000_F0F0_0000;
  localparam logic [63:0] JUNK = 64'hDEAD_DEAD_DEAD_DEAD;
  localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

  typedef struct {
    logic        write;
    logic [63:0] addr;
    logic [63:0] wdata;
  } op_t;

  typedef struct {
    int          id;
    logic        write;
    logic [63:0] addr;
    logic [63:0] wdata;
    int          gap;   // cycles since previous grant, -1 = don't care
  } req_exp_t;

  typedef struct {
    int          id;
    logic        err;
    logic [63:0] rdata;
    int          lat;   // cycles from grant to ready pulse
  } rsp_exp_t;

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic [NC-1:0]         core_req;
  logic [NC-1:0]         core_write;
  logic [NC-1:0][AW-1:0] core_addr;
  logic [NC-1:0][DW-1:0] core_wdata;
  logic [NC-1:0][DW-1:0] core_rdata;
  logic [NC-1:0]         core_ready;
  logic [NC-1:0]         core_err;
  logic                  m_req;
  logic                  m_write;
  logic [AW-1:0]         m_addr;
  logic [DW-1:0]         m_wdata;
  logic [DW-1:0]         m_rdata;
  logic                  m_ready;
  logic [IDW-1:0]        grant_id;
  logic                  busy;

  int          n_checks = 0;
  int          n_fail   = 0;
  op_t         op_q[NC][$];
  req_exp_t    exp_req_q[$];
  rsp_exp_t    exp_rsp_q[$];
  logic [63:0] rdata_model[NC];

  int          ctl_lat;
  bit          ctl_xor;
  logic [63:0] ctl_data;
  bit          ctl_spurious;
  bit          flush;

  always #5 clk = ~clk;

  mem_req_arbiter #(
    .NUM_CORES      (NC),
    .ADDR_WIDTH     (AW),
    .DATA_WIDTH     (DW),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .core_req   (core_req),
    .core_write (core_write),
    .core_addr  (core_addr),
    .core_wdata (core_wdata),
    .core_rdata (core_rdata),
    .core_ready (core_ready),
    .core_err   (core_err),
    .m_req      (m_req),
    .m_write    (m_write),
    .m_addr     (m_addr),
    .m_wdata    (m_wdata),
    .m_rdata    (m_rdata),
    .m_ready    (m_ready),
    .grant_id   (grant_id),
    .busy       (busy)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Queue one core operation plus the grant (and optionally response) it must produce.
  task automatic issue(input int id, input logic wr, input logic [63:0] addr,
                       input logic [63:0] wdata, input int gap, input bit want_rsp,
                       input logic err, input logic [63:0] rdata, input int lat);
    op_t      o;
    req_exp_t q;
    rsp_exp_t r;
    o.write = wr; o.addr = addr; o.wdata = wdata;
    op_q[id].push_back(o);
    q.id = id; q.write = wr; q.addr = addr; q.wdata = wdata; q.gap = gap;
    exp_req_q.push_back(q);
    if (want_rsp) begin
      r.id = id; r.err = err; r.rdata = rdata; r.lat = lat;
      exp_rsp_q.push_back(r);
    end
  endtask

  function automatic bit pending();
    bit p;
    p = (exp_req_q.size() != 0) || (exp_rsp_q.size() != 0);
    for (int i = 0; i < NC; i++) if (op_q[i].size() != 0) p = 1'b1;
    return p;
  endfunction

  task automatic wait_done(input string name, input int max_cycles);
    int n;
    n = 0;
    while (pending() && n < max_cycles) begin
      @(negedge clk);
      n++;
    end
    check(name, {63'd0, pending()}, 64'd0);
    repeat (3) @(negedge clk);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_m_req"},      {63'd0, m_req}, 64'd0);
    check({tag, "_m_write"},    {63'd0, m_write}, 64'd0);
    check({tag, "_m_addr"},     m_addr, 64'd0);
    check({tag, "_m_wdata"},    m_wdata, 64'd0);
    check({tag, "_busy"},       {63'd0, busy}, 64'd0);
    check({tag, "_grant_id"},   {62'd0, grant_id}, 64'd0);
    check({tag, "_core_ready"}, {60'd0, core_ready}, 64'd0);
    check({tag, "_core_err"},   {60'd0, core_err}, 64'd0);
    for (int i = 0; i < NC; i++) check({tag, "_core_rdata"}, core_rdata[i], 64'd0);
  endtask

  // Controller model: answers on the ctl_lat-th WAIT cycle (0 = first), never if negative.
  initial begin
    int wcnt;
    wcnt    = 0;
    m_ready = 1'b0;
    m_rdata = '0;
    forever begin
      @(negedge clk);
      if (m_req && rst_n) begin
        if (ctl_lat >= 0 && wcnt == ctl_lat) begin
          m_ready = 1'b1;
          m_rdata = ctl_xor ? (m_addr ^ XK) : ctl_data;
        end else begin
          m_ready = 1'b0;
          m_rdata = JUNK;
        end
        wcnt++;
      end else begin
        wcnt    = 0;
        m_ready = ctl_spurious;
        m_rdata = ~JUNK;
      end
    end
  end

  // Core model: holds a request until its ready pulse, then loads the next op.
  initial begin
    op_t o;
    core_req   = '0;
    core_write = '0;
    core_addr  = '0;
    core_wdata = '0;
    forever begin
      @(negedge clk);
      for (int i = 0; i < NC; i++) begin
        if (flush) begin
          core_req[i] = 1'b0;
        end else begin
          if (core_ready[i]) core_req[i] = 1'b0;
          if (!core_req[i] && op_q[i].size() != 0) begin
            o             = op_q[i].pop_front();
            core_write[i] = o.write;
            core_addr[i]  = o.addr;
            core_wdata[i] = o.wdata;
            core_req[i]   = 1'b1;
          end
        end
      end
    end
  end

  // Monitor / scoreboard.
  initial begin
    int       cyc;
    int       last_grant;
    logic     prev_m_req;
    logic [NC-1:0] prev_ready;
    req_exp_t q;
    rsp_exp_t r;
    cyc = 0; last_grant = 0; prev_m_req = 1'b0; prev_ready = '0;
    for (int i = 0; i < NC; i++) rdata_model[i] = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_m_req = 1'b0;
        prev_ready = '0;
        for (int i = 0; i < NC; i++) rdata_model[i] = '0;
      end else begin
        cyc++;
        if (m_req && !prev_m_req) begin
          if (exp_req_q.size() == 0) begin
            check("unexpected_grant", {62'd0, grant_id}, 64'hFFFF);
          end else begin
            q = exp_req_q.pop_front();
            check("grant_id", {62'd0, grant_id}, 64'(q.id));
            check("m_write",  {63'd0, m_write}, {63'd0, q.write});
            check("m_addr",   m_addr, q.addr);
            check("m_wdata",  m_wdata, q.wdata);
            check("busy_wait", {63'd0, busy}, 64'd1);
            if (q.gap >= 0) check("grant_gap", 64'(cyc - last_grant), 64'(q.gap));
          end
          last_grant = cyc;
        end
        if (core_ready != '0) begin
          check("ready_pulse_width", {60'd0, prev_ready & core_ready}, 64'd0);
          if (exp_rsp_q.size() == 0) begin
            check("unexpected_ready", {60'd0, core_ready}, 64'd0);
          end else begin
            r = exp_rsp_q.pop_front();
            rdata_model[r.id] = r.rdata;
            check("ready_vec",   {60'd0, core_ready}, 64'd1 << r.id);
            check("err_vec",     {60'd0, core_err}, r.err ? (64'd1 << r.id) : 64'd0);
            check("core_rdata",  core_rdata[r.id], r.rdata);
            check("rsp_latency", 64'(cyc - last_grant), 64'(r.lat));
            check("m_req_low",   {63'd0, m_req}, 64'd0);
            check("busy_resp",   {63'd0, busy}, 64'd1);
            for (int i = 0; i < NC; i++)
              if (i != r.id) check("rdata_other", core_rdata[i], rdata_model[i]);
          end
        end else begin
          check_err_idle: if (core_err != '0) check("err_without_ready", {60'd0, core_err}, 64'd0);
        end
        prev_m_req = m_req;
        prev_ready = core_ready;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, checks=%0d", n_checks);
    $fatal(1, "global timeout");
  end

  // Directed stimulus.
  initial begin
    ctl_lat = 0; ctl_xor = 1'b0; ctl_data = '0; ctl_spurious = 1'b0; flush = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs("por");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Round-robin: all four cores request at once, core0 twice; 0-cycle controller.
    ctl_lat = 0; ctl_xor = 1'b1;
    issue(0, 1'b0, 64'h1000_0000, '0, -1, 1'b1, 1'b0, 64'h1000_0000 ^ XK, 1);
    issue(1, 1'b0, 64'h1000_0100, '0,  3, 1'b1, 1'b0, 64'h1000_0100 ^ XK, 1);
    issue(2, 1'b0, 64'h1000_0200, '0,  3, 1'b1, 1'b0, 64'h1000_0200 ^ XK, 1);
    issue(3, 1'b0, 64'h1000_0300, '0,  3, 1'b1, 1'b0, 64'h1000_0300 ^ XK, 1);
    issue(0, 1'b0, 64'h1000_0008, '0,  3, 1'b1, 1'b0, 64'h1000_0008 ^ XK, 1);
    wait_done("rr_done", 100);

    // Single load from core0.
    ctl_xor = 1'b0; ctl_lat = 0; ctl_data = 64'h1122_3344_5566_7788;
    issue(0, 1'b0, 64'h8000_0010, '0, -1, 1'b1, 1'b0, 64'h1122_3344_5566_7788, 1);
    wait_done("load_done", 50);

    // Store from core1: rdata keeps its earlier load value.
    ctl_lat = 1; ctl_data = 64'h0000_0000_0000_BAD0;
    issue(1, 1'b1, 64'h8000_0100, 64'hCAFE, -1, 1'b1, 1'b0, 64'h1000_0100 ^ XK, 2);
    wait_done("store_done", 50);

    // Timeout: controller never answers; then a normal load succeeds.
    ctl_lat = -1;
    issue(0, 1'b0, 64'h8000_0200, '0, -1, 1'b1, 1'b1, ONES, TO);
    wait_done("timeout_done", 50);
    ctl_lat = 2; ctl_data = 64'h0123_4567_89AB_CDEF;
    issue(0, 1'b0, 64'h8000_0208, '0, -1, 1'b1, 1'b0, 64'h0123_4567_89AB_CDEF, 3);
    wait_done("after_timeout_done", 50);

    // Tie: m_ready arrives on the timeout cycle.
    ctl_lat = TO - 1; ctl_data = 64'h55;
    issue(1, 1'b0, 64'h8000_0300, '0, -1, 1'b1, 1'b0, 64'h55, TO);
    wait_done("tie_done", 50);

    // m_ready outside WAIT must be ignored.
    ctl_spurious = 1'b1;
    repeat (6) @(negedge clk);
    ctl_lat = 0; ctl_data = 64'h2222;
    issue(2, 1'b0, 64'h8000_0400, '0, -1, 1'b1, 1'b0, 64'h2222, 1);
    wait_done("spurious_done", 50);
    ctl_spurious = 1'b0;

    // Reset mid-WAIT: core3 in flight (pointer now 3), reset abandons it.
    ctl_lat = -1;
    issue(3, 1'b0, 64'h8000_0500, '0, -1, 1'b0, 1'b0, '0, 0);
    begin
      int n;
      n = 0;
      while (exp_req_q.size() != 0 && n < 50) begin
        @(negedge clk);
        n++;
      end
      check("rst_grant_seen", 64'(exp_req_q.size()), 64'd0);
    end
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b0;
    #1 check_reset_outputs("mid");
    flush = 1'b1;
    @(negedge clk);
    #1 flush = 1'b0;
    ctl_lat = 0; ctl_data = 64'h3333;
    issue(2, 1'b0, 64'h8000_0600, '0, -1, 1'b1, 1'b0, 64'h3333, 1);
    issue(3, 1'b0, 64'h8000_0700, '0,  3, 1'b1, 1'b0, 64'h3333, 1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    wait_done("post_reset_done", 60);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
